// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit owning the architectural Hi/Lo registers.
// Optional MTHI/MTLO write ports are enabled by defining MDU_MTHILO_EN.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MultStart,
    input  logic             DivStart,
`ifdef MDU_MTHILO_EN
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] HiLoData,
`endif
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             divzero_q, divzero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             last_step;

    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    logic [W2-1:0]    mul_signed;

    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [W2-1:0]    div_next;
    logic [WIDTH-1:0] div_quo, div_rem;

    assign a_neg     = A[WIDTH-1];
    assign b_neg     = B[WIDTH-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;
    assign last_step = (cnt_q == CNT_W'(1));

    // Multiply: prod_q = {partial sum, remaining multiplier bits}, shifted right each step.
    assign mul_sum    = {1'b0, prod_q[W2-1:WIDTH]}
                      + (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
    assign mul_next   = {mul_sum, prod_q[WIDTH-1:1]};
    assign mul_signed = neg_res_q ? -mul_next : mul_next;

    // Divide: prod_q = {partial remainder, dividend bits becoming quotient bits}.
    // A borrow out of the W+1 bit trial subtract means the divisor did not fit.
    assign div_shift = {prod_q[W2-1:WIDTH], prod_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        prod_q[WIDTH-2:0], div_ge};
    assign div_quo   = neg_res_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign div_rem   = neg_rem_q ? -div_next[W2-1:WIDTH] : div_next[W2-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prod_q    <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divzero_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prod_q    <= prod_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divzero_q <= divzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divzero_d = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (MultStart) begin
                    state_d   = S_MULT;
                    cnt_d     = CNT_W'(WIDTH);
                    opnd_d    = a_mag;
                    prod_d    = {{WIDTH{1'b0}}, b_mag};
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = 1'b0;
                end else if (DivStart) begin
                    if (B == '0) begin
                        state_d   = S_DONE;
                        divzero_d = 1'b1;
                    end else begin
                        state_d   = S_DIV;
                        cnt_d     = CNT_W'(WIDTH);
                        opnd_d    = b_mag;
                        prod_d    = {{WIDTH{1'b0}}, a_mag};
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                    end
                end
`ifdef MDU_MTHILO_EN
                else begin
                    if (HiWrite) hi_d = HiLoData;
                    if (LoWrite) lo_d = HiLoData;
                end
`endif
            end
            S_MULT: begin
                prod_d = mul_next;
                cnt_d  = cnt_q - CNT_W'(1);
                if (last_step) begin
                    state_d      = S_DONE;
                    {hi_d, lo_d} = mul_signed;
                end
            end
            S_DIV: begin
                prod_d = div_next;
                cnt_d  = cnt_q - CNT_W'(1);
                if (last_step) begin
                    state_d = S_DONE;
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                end
            end
            S_DONE: begin
                // divzero_q is still held here so DivZero pulses with Done.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy    = (state_q != S_IDLE);
    assign Done    = (state_q == S_DONE);
    assign DivZero = (state_q == S_DONE) && divzero_q;
    assign Hi      = hi_q;
    assign Lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: cycle-timeline reference model, per-cycle compare and result scoreboard.
// Define MDU_MTHILO_EN for both bench and RTL to exercise the Hi/Lo write ports.
module tb_mult_div_unit;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [WIDTH-1:0]  A = '0;
    logic [WIDTH-1:0]  B = '0;
    logic              MultStart = 1'b0;
    logic              DivStart = 1'b0;
`ifdef MDU_MTHILO_EN
    logic              HiWrite = 1'b0;
    logic              LoWrite = 1'b0;
    logic [WIDTH-1:0]  HiLoData = '0;
`endif
    logic              Busy, Done, DivZero;
    logic [WIDTH-1:0]  Hi, Lo;

    int n_checks = 0;
    int n_errors = 0;

    mult_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .MultStart (MultStart),
        .DivStart  (DivStart),
`ifdef MDU_MTHILO_EN
        .HiWrite   (HiWrite),
        .LoWrite   (LoWrite),
        .HiLoData  (HiLoData),
`endif
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] mult_ref(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b);
        longint q, r;
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        return {r[31:0], q[31:0]};
    endfunction

    // ---------------- timeline model ----------------
    // m_left counts the busy cycles still to come; the cycle with m_left==1 is the Done cycle.
    int                m_left = 0;
    bit                m_dz = 1'b0;
    logic [63:0]       m_res = '0;
    logic [WIDTH-1:0]  m_hi = '0;
    logic [WIDTH-1:0]  m_lo = '0;
    logic [63:0]       exp_q[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0;
            m_dz   = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            exp_q.delete();
        end else if (m_left != 0) begin
            m_left--;
            if (m_left == 1 && !m_dz) {m_hi, m_lo} = m_res;
        end else if (MultStart) begin
            m_res  = mult_ref(A, B);
            m_dz   = 1'b0;
            m_left = WIDTH + 1;
            exp_q.push_back(m_res);
        end else if (DivStart) begin
            if (B == 0) begin
                m_dz   = 1'b1;
                m_left = 1;
                exp_q.push_back({m_hi, m_lo});
            end else begin
                m_res  = div_ref(A, B);
                m_dz   = 1'b0;
                m_left = WIDTH + 1;
                exp_q.push_back(m_res);
            end
        end
`ifdef MDU_MTHILO_EN
        else begin
            if (HiWrite) m_hi = HiLoData;
            if (LoWrite) m_lo = HiLoData;
        end
`endif
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [63:0] sb;
        forever begin
            @(negedge clk);
            chk("busy", 64'(Busy), 64'(m_left != 0));
            chk("done", 64'(Done), 64'(m_left == 1));
            chk("divzero", 64'(DivZero), 64'(m_left == 1 && m_dz));
            chk("hi", 64'(Hi), 64'(m_hi));
            chk("lo", 64'(Lo), 64'(m_lo));
            if (m_left == 1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 64'(exp_q.size()), 64'd1);
                end else begin
                    sb = exp_q.pop_front();
                    chk("sb_result", {Hi, Lo}, sb);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All driver actions start 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                          input int inj, input string tag,
                          output logic [63:0] res, output logic dz);
        int lat;
        int exp_lat;
        exp_lat = (m || b != 0) ? WIDTH + 1 : 1;
        A = a;
        B = b;
        MultStart = m;
        DivStart  = d;
`ifdef MDU_MTHILO_EN
        HiWrite  = 1'($urandom_range(0, 1));
        LoWrite  = 1'($urandom_range(0, 1));
        HiLoData = $urandom;
`endif
        step();
        MultStart = 1'b0;
        DivStart  = 1'b0;
`ifdef MDU_MTHILO_EN
        HiWrite = 1'b0;
        LoWrite = 1'b0;
`endif
        A = $urandom;
        B = $urandom;
        lat = 0;
        res = '0;
        dz  = 1'b0;
        for (int i = 1; i <= WIDTH + 10; i++) begin
            if (Done) begin
                lat = i;
                res = {Hi, Lo};
                dz  = DivZero;
                break;
            end
            if (i == inj) begin
                DivStart  = 1'b1;
                MultStart = 1'($urandom_range(0, 1));
            end
            step();
            MultStart = 1'b0;
            DivStart  = 1'b0;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        step();
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
`ifdef MDU_MTHILO_EN
            HiWrite  = ($urandom_range(0, 3) == 0);
            LoWrite  = ($urandom_range(0, 3) == 0);
            HiLoData = $urandom;
`endif
            step();
`ifdef MDU_MTHILO_EN
            HiWrite = 1'b0;
            LoWrite = 1'b0;
`endif
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] res;
        logic        dz;

        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_done", 64'(Done), 64'd0);
        chk("reset_divzero", 64'(DivZero), 64'd0);
        chk("reset_hilo", {Hi, Lo}, 64'd0);
        reset = 1'b0;
        step();

        // 7 * -3
        run_op(1, 0, 32'd7, 32'hFFFFFFFD, 0, "t1_mult", res, dz);
        chk("t1_hilo", res, 64'hFFFFFFFF_FFFFFFEB);

        // -7 / 2 and the overflow case
        run_op(0, 1, 32'hFFFFFFF9, 32'd2, 0, "t2_div", res, dz);
        chk("t2_hilo", res, 64'hFFFFFFFF_FFFFFFFD);
        run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 0, "t2_ovf", res, dz);
        chk("t2_ovf_hilo", res, 64'h00000000_80000000);
        chk("t2_ovf_dz", 64'(dz), 64'd0);

        // preload Hi/Lo = 0x11/0x22 by multiply, then divide by zero
        run_op(1, 0, 32'h66, 32'h2AAAAAAB, 0, "t3_pre", res, dz);
        chk("t3_pre_hilo", res, 64'h00000011_00000022);
        run_op(0, 1, 32'd5, 32'd0, 0, "t3_dz", res, dz);
        chk("t3_dz_hilo", res, 64'h00000011_00000022);
        chk("t3_dz_flag", 64'(dz), 64'd1);

        // both starts: multiply wins
        run_op(1, 1, 32'h10000, 32'h10000, 0, "t4_both", res, dz);
        chk("t4_hilo", res, 64'h00000001_00000000);

        // start pulse during multiply is ignored
        run_op(1, 0, 32'd6, 32'd7, 5, "t5_ign", res, dz);
        chk("t5_hilo", res, 64'h00000000_0000002A);

        // reset in cycle 10 of a divide
        A = 32'd1000;
        B = 32'd7;
        DivStart = 1'b1;
        step();
        DivStart = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(Busy), 64'd0);
        chk("t5_rst_hilo", {Hi, Lo}, 64'd0);
        step();
        reset = 1'b0;
        repeat (3) step();
        chk("t5_rst_nodone", 64'(Done), 64'd0);

`ifdef MDU_MTHILO_EN
        HiWrite  = 1'b1;
        HiLoData = 32'hCAFE;
        step();
        HiWrite = 1'b0;
        chk("t6_mthi", 64'(Hi), 64'h0000CAFE);
        A = 32'd3;
        B = 32'd4;
        HiWrite   = 1'b1;
        HiLoData  = 32'h1234;
        MultStart = 1'b1;
        step();
        HiWrite   = 1'b0;
        MultStart = 1'b0;
        chk("t6_drop_busy", 64'(Busy), 64'd1);
        chk("t6_drop_hi", 64'(Hi), 64'h0000CAFE);
        repeat (WIDTH + 1) step();
        chk("t6_prod", {Hi, Lo}, 64'h00000000_0000000C);
`endif

        // randomized operations
        for (int n = 0; n < 40; n++) begin
            int          sel;
            int          inj;
            logic [31:0] ra, rb;
            bit          rm, rd;
            sel = $urandom_range(0, 7);
            ra  = $urandom;
            rb  = $urandom;
            case (sel)
                0: rb = 32'd0;
                1: begin
                    ra = 32'h80000000;
                    rb = 32'hFFFFFFFF;
                end
                2: begin
                    ra = 32'($urandom_range(0, 40)) - 32'd20;
                    rb = 32'($urandom_range(0, 40)) - 32'd20;
                end
                default: ;
            endcase
            rm  = 1'($urandom_range(0, 1));
            rd  = !rm || ($urandom_range(0, 3) == 0);
            inj = ((rm || rb != 0) && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, WIDTH)) : 0;
            run_op(rm, rd, ra, rb, inj, "rand", res, dz);
            idle_gap(int'($urandom_range(0, 3)));
        end

        repeat (3) step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
